// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM state
// encoding, the default operand width and a counter-width helper.
package serial_arith_pkg;

  // Default operand/result width in bits.
  localparam int SS_DEFAULT_WIDTH = 8;

  // Controller states shared by the serial arithmetic blocks.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Number of bits needed to count 0..value-1; never returns less than 1
  // so the smallest legal width still gets a real counter register.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Combinational 1-bit full subtractor: d = x - y - bin, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bo
);

  logic w_xy_diff;

  // Borrow is generated when x=0,y=1, and propagated when x==y.
  always_comb begin
    w_xy_diff = x ^ y;
    d         = w_xy_diff ^ bin;
    bo        = (~x & y) | (~w_xy_diff & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), LSB first, one bit per
// clock, with a start/busy/done handshake.
// Optional feature macro: SERIAL_SUB_OVF_EN adds a signed-overflow output
// 'ovf' that is updated and held alongside diff.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SS_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
  output logic             bout,
  output logic             ovf
`else
  output logic             bout
`endif
);

  localparam int CW = clog2(WIDTH);

  // Controller state.
  state_t r_state;
  state_t w_state_next;

  // Operand shift registers; bit 0 is the bit currently being processed.
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;

  // Partial result: holds the WIDTH-1 most recently produced bits. The
  // result register is only written on the final edge, so consumers never
  // see partial values during RUN.
  logic [WIDTH-2:0] r_d_sr;
  logic [WIDTH-1:0] w_d_shift;

  logic             r_br;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_bout;

  logic w_d;
  logic w_bo;
  logic w_accept;
  logic w_run;
  logic w_last;

  full_subtractor u_fs (
    .x   (r_a_sr[0]),
    .y   (r_b_sr[0]),
    .bin (r_br),
    .d   (w_d),
    .bo  (w_bo)
  );

  // Decode handshake conditions and form the shifted partial result.
  always_comb begin
    w_accept  = (r_state == ST_IDLE) && start;
    w_run     = (r_state == ST_RUN);
    w_last    = w_run && (r_cnt == CW'(WIDTH - 1));
    w_d_shift = {w_d, r_d_sr};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: IDLE waits for start, RUN lasts WIDTH edges, DONE
  // lasts exactly one cycle.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand capture, per-bit shifting, borrow chain and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sr <= '0;
      r_b_sr <= '0;
      r_d_sr <= '0;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_accept) begin
      r_a_sr <= a;
      r_b_sr <= b;
      r_br   <= 1'b0;
      r_cnt  <= '0;
    end else if (w_run) begin
      r_a_sr <= r_a_sr >> 1;
      r_b_sr <= r_b_sr >> 1;
      r_d_sr <= w_d_shift[WIDTH-1:1];
      r_br   <= w_bo;
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Result registers: loaded only on the edge that processes the MSB, then
  // held until the next operation completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_last) begin
      r_diff <= w_d_shift;
      r_bout <= w_bo;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Signed overflow from the operand MSBs (still in bit 0 of the shift
  // registers on the final edge) and the result MSB being produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a_sr[0] ^ r_b_sr[0]) & (r_a_sr[0] ^ w_d);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);
  assign diff = r_diff;
  assign bout = r_bout;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8): vector table,
// hand-written handshake sequences and randomized operations checked
// against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_diff;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
`ifdef SERIAL_SUB_OVF_EN
    .bout  (bout),
    .ovf   (ovf)
`else
    .bout  (bout)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, wrapped into W bits.
  function automatic logic [W+1:0] ref_sub(input int unsigned x, input int unsigned y);
    int r;
    int sx;
    int sy;
    int sr;
    logic bo;
    logic ov;
    r  = int'(x) - int'(y);
    bo = (r < 0);
    if (r < 0) r += (1 << W);
    sx = (x >= (1 << (W - 1))) ? int'(x) - (1 << W) : int'(x);
    sy = (y >= (1 << (W - 1))) ? int'(y) - (1 << W) : int'(y);
    sr = sx - sy;
    ov = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
    return {ov, bo, r[W-1:0]};
  endfunction

  // One full transaction with latency, busy-length, hold and result checks.
  task automatic do_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input string tag);
    logic [W-1:0] prev_d;
    logic         prev_b;
    int           lat;
    int           busy_cnt;
    logic         hold_ok;
    logic [W-1:0] got_d;
    logic         got_b;
    prev_d = diff;
    prev_b = bout;
    @(negedge clk);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    busy_cnt = busy ? 1 : 0;
    hold_ok  = (diff === prev_d) && (bout === prev_b);
    lat      = 0;
    while (!done && lat < W + 12) begin
      @(negedge clk);
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
      @(posedge clk); #1;
      lat++;
      if (busy) busy_cnt++;
      if (!done && (diff !== prev_d || bout !== prev_b)) hold_ok = 1'b0;
    end
    got_d = diff;
    got_b = bout;
    $display("op %s a=0x%02h b=0x%02h diff=0x%02h bout=%0d lat=%0d", tag, aa, bb, got_d, got_b, lat);
    chk({tag, "_latency"}, lat, W);
    chk({tag, "_busy_len"}, busy_cnt, W);
    chk({tag, "_hold_run"}, hold_ok, 1);
    chk({tag, "_diff"}, got_d, ed);
    chk({tag, "_bout"}, got_b, eb);
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, ovf, eo);
`else
    if (eo === 1'bx) $display("note: unexpected x in ovf expectation");
`endif
    @(negedge clk);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {busy, done}, 2'b00);
    chk({tag, "_hold_idle"}, {bout, diff}, {eb, ed});
  endtask

  initial begin
    vec_t vecs[10];
    logic [W+1:0] m;
    int ndone;
    logic pulse_next;
    int pulse_at[$];
    logic seen_first;
    logic stable_ok;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{8'd10, 8'd3,  8'h07, 1'b0, 1'b0};
    vecs[1] = '{8'd3,  8'd10, 8'hF9, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h5A, 8'h5A, 8'h00, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[5] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[6] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
    vecs[7] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};
    vecs[8] = '{8'h00, 8'hFF, 8'h01, 1'b1, 1'b0};
    vecs[9] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b1};

    // Reset state.
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("reset_state", {busy, done, bout, diff}, '0);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].va, vecs[i].vb, vecs[i].exp_diff, vecs[i].exp_bout,
            vecs[i].exp_ovf, $sformatf("vec%0d", i));
    end

    // start pulses during RUN and DONE are ignored.
    ndone = 0;
    pulse_next = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == 3) || pulse_next;
      a = (c == 0) ? 8'hFF : 8'h00;
      b = (c == 0) ? 8'h01 : 8'h00;
      @(posedge clk); #1;
      pulse_next = done;
      if (done) ndone++;
    end
    @(negedge clk);
    start = 1'b0;
    $display("op ignore_start diff=0x%02h bout=%0d dones=%0d", diff, bout, ndone);
    chk("ignore_start_ndone", ndone, 1);
    chk("ignore_start_diff", diff, 8'hFE);
    chk("ignore_start_bout", bout, 0);
    chk("ignore_start_idle", busy, 0);

    // Reset during the 4th RUN cycle discards the operation.
    @(negedge clk);
    a = 8'h80; b = 8'h01; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_state", {busy, done, bout, diff}, '0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    $display("op midrst dones_after=%0d", ndone);
    chk("midrst_no_done", ndone, 0);

    // start held high: one result every W+2 cycles, diff stable between.
    @(negedge clk);
    a = 8'd20; b = 8'd5; start = 1'b1;
    seen_first = 1'b0;
    stable_ok = 1'b1;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (done) begin
        pulse_at.push_back(c);
        seen_first = 1'b1;
        $display("op held_start pulse at cycle %0d diff=0x%02h", c, diff);
      end
      if (seen_first && diff !== 8'h0F) stable_ok = 1'b0;
      if (!seen_first && diff !== 8'h00) stable_ok = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("held_npulses", pulse_at.size(), 3);
    if (pulse_at.size() == 3) begin
      chk("held_first", pulse_at[0], W);
      chk("held_gap1", pulse_at[1] - pulse_at[0], W + 2);
      chk("held_gap2", pulse_at[2] - pulse_at[1], W + 2);
    end
    chk("held_stable", stable_ok, 1);
    repeat (3) @(posedge clk);
    #1;

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 8 == 0) rb = ra;
      m = ref_sub(ra, rb);
      do_op(ra, rb, m[W-1:0], m[W], m[W+1], $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
